// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: mode constants, default word width and the slave FSM states.
// The SPI master imports the same package so both ends agree on framing.
package spi_slave_pkg;

    localparam int SPI_DWIDTH      = 8;
    localparam bit SPI_CPOL        = 1'b0;
    localparam bit SPI_CPHA        = 1'b0;
    localparam bit SPI_MSB_FIRST   = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a selectable reset level
// so an idle pin does not produce a spurious edge when reset is released.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) with a one-word TX holding register and a
// one-word RX output register with overrun detection. All pins are oversampled on clk.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                DWIDTH      = SPI_DWIDTH,
    parameter logic [DWIDTH-1:0] FILL        = {DWIDTH{1'b0}},
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DWIDTH-1:0] tx_din,
    input  logic              tx_wr,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_dout,
    output logic              rx_valid,
    input  logic              rx_rd,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(DWIDTH + 1);

    spi_state_e        state, next_state;
    logic              sclk_s, ss_s, mosi_s;
    logic              sclk_d, ss_d;
    logic              sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [CW-1:0]     bit_cnt;
    logic              word_done, reload_pend;
    logic              frame_start, consume;
    logic [DWIDTH-1:0] consume_val;
    logic [DWIDTH-1:0] tx_shift, rx_shift, hold;
    logic              hold_full;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d(ss_n), .q(ss_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d <= 1'b0;
            ss_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                busy = 1'b1;
                if (ss_rise) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The holding register is drained at frame start and at every word boundary.
    assign frame_start = (state == IDLE) && ss_fall;
    assign word_done   = (state == ACTIVE) && (bit_cnt == CW'(DWIDTH));
    assign consume     = frame_start || ((state == ACTIVE) && sclk_fall && reload_pend);
    assign consume_val = hold_full ? hold : FILL;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift    <= FILL;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else if (frame_start) begin
            tx_shift    <= consume_val;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else if (state == ACTIVE) begin
            if (sclk_rise) begin
                rx_shift <= {rx_shift[DWIDTH-2:0], mosi_s};
                bit_cnt  <= bit_cnt + CW'(1);
            end else if (word_done) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b1;
            end
            if (sclk_fall) begin
                tx_shift    <= reload_pend ? consume_val : {tx_shift[DWIDTH-2:0], 1'b0};
                reload_pend <= 1'b0;
            end
        end
    end

    // A write landing on the same clk as a consume refills the register immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (tx_wr && (!hold_full || consume)) begin
            hold      <= tx_din;
            hold_full <= 1'b1;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    // Word completion takes priority over a simultaneous read acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_dout  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (word_done) begin
            rx_dout  <= rx_shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_rd) begin
                overrun <= 1'b1;
            end
        end else if (rx_rd) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign miso     = tx_shift[DWIDTH-1];
    assign miso_oe  = ~ss_s;
    assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: a bit-banged SPI master plus a transaction-level
// model of the TX holding register and RX flags, compared every idle cycle.
module tb_spi_slave;

    localparam int   HALF = 6;
    localparam logic [7:0] FILL_W = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, ss_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_din;
    logic       tx_wr;
    logic       tx_ready;
    logic [7:0] rx_dout;
    logic       rx_valid;
    logic       rx_rd;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit settled  = 1'b0;

    logic [7:0] m_hold;
    bit         m_hold_full;
    logic [7:0] m_rx_dout;
    bit         m_rx_valid;
    bit         m_overrun;
    logic [7:0] recv [2];

    spi_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_din(tx_din), .tx_wr(tx_wr),
        .tx_ready(tx_ready), .rx_dout(rx_dout), .rx_valid(rx_valid),
        .rx_rd(rx_rd), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] m_consume();
        logic [7:0] w;
        w = m_hold_full ? m_hold : FILL_W;
        m_hold_full = 1'b0;
        return w;
    endfunction

    task automatic m_reset();
        m_hold      = '0;
        m_hold_full = 1'b0;
        m_rx_dout   = '0;
        m_rx_valid  = 1'b0;
        m_overrun   = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        settled = 1'b1;
    endtask

    task automatic pulse_tx_wr(input logic [7:0] d);
        @(negedge clk);
        tx_din = d;
        tx_wr  = 1'b1;
        if (!m_hold_full) begin
            m_hold      = d;
            m_hold_full = 1'b1;
        end
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic write_tx(input logic [7:0] d);
        settled = 1'b0;
        pulse_tx_wr(d);
        settle();
    endtask

    task automatic read_rx();
        settled = 1'b0;
        @(negedge clk);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd      = 1'b0;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
        settle();
    endtask

    task automatic do_reset();
        settled = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        settle();
    endtask

    // stop_bits > 0 leaves the frame open after that many bits so the caller can abort it.
    task automatic spi_frame(input int nwords, input logic [7:0] wa, input logic [7:0] wb,
                             input int stop_bits, input bit mid_wr, input logic [7:0] mid_data);
        logic [7:0] words [2];
        logic [7:0] exp_miso;
        logic [7:0] got;
        int         bits_sent;
        words[0]  = wa;
        words[1]  = wb;
        bits_sent = 0;
        settled   = 1'b0;
        @(negedge clk);
        ss_n     = 1'b0;
        mosi     = wa[7];
        exp_miso = m_consume();
        repeat (8) @(negedge clk);
        check_output("busy_in_frame", busy, 1);
        check_output("miso_oe_in_frame", miso_oe, 1);
        for (int w = 0; w < nwords; w++) begin
            got = '0;
            for (int b = 7; b >= 0; b--) begin
                mosi = words[w][b];
                if (mid_wr && w == 0 && b == 4) begin
                    pulse_tx_wr(mid_data);
                    repeat (HALF - 2) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                sclk = 1'b1;
                got  = {got[6:0], miso};
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
                bits_sent++;
                if (stop_bits != 0 && bits_sent == stop_bits) begin
                    return;
                end
            end
            if (m_rx_valid) begin
                m_overrun = 1'b1;
            end
            m_rx_valid = 1'b1;
            m_rx_dout  = words[w];
            recv[w]    = got;
            check_output("miso_word", got, exp_miso);
            exp_miso = m_consume();
            @(negedge clk);
            check_output("rx_valid_after_word", rx_valid, m_rx_valid);
            check_output("rx_dout_after_word", rx_dout, m_rx_dout);
        end
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (settled && !rst) begin
            check_output("cmp_rx_dout", rx_dout, m_rx_dout);
            check_output("cmp_rx_valid", rx_valid, m_rx_valid);
            check_output("cmp_overrun", overrun, m_overrun);
            check_output("cmp_tx_ready", tx_ready, !m_hold_full);
            check_output("cmp_busy", busy, 0);
            check_output("cmp_miso_oe", miso_oe, 0);
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        sclk   = 1'b0;
        ss_n   = 1'b1;
        mosi   = 1'b0;
        tx_din = '0;
        tx_wr  = 1'b0;
        rx_rd  = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_output("rst_tx_ready", tx_ready, 1);
        check_output("rst_rx_valid", rx_valid, 0);
        check_output("rst_rx_dout", rx_dout, 8'h00);
        check_output("rst_overrun", overrun, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_miso_oe", miso_oe, 0);
        check_output("rst_miso", miso, 0);
        do_reset();

        $display("[TB] preload A5, master sends 3C; second write while full is ignored");
        write_tx(8'hA5);
        check_output("t1_tx_ready_full", tx_ready, 0);
        write_tx(8'h77);
        spi_frame(1, 8'h3C, 8'h00, 0, 1'b0, 8'h00);
        settle();
        check_output("t1_master_rx", recv[0], 8'hA5);
        check_output("t1_rx_dout", rx_dout, 8'h3C);
        check_output("t1_rx_valid", rx_valid, 1);
        check_output("t1_tx_ready", tx_ready, 1);
        read_rx();

        $display("[TB] no preload, master sends FF");
        spi_frame(1, 8'hFF, 8'h00, 0, 1'b0, 8'h00);
        settle();
        check_output("t2_master_rx", recv[0], 8'h00);
        check_output("t2_rx_dout", rx_dout, 8'hFF);
        read_rx();

        $display("[TB] two-word frame, 22 written during word 1");
        write_tx(8'h11);
        spi_frame(2, 8'hC5, 8'h5C, 0, 1'b1, 8'h22);
        settle();
        check_output("t3_master_rx0", recv[0], 8'h11);
        check_output("t3_master_rx1", recv[1], 8'h22);
        check_output("t3_rx_dout", rx_dout, 8'h5C);
        read_rx();

        $display("[TB] two words without read -> overrun");
        spi_frame(2, 8'h12, 8'h34, 0, 1'b0, 8'h00);
        settle();
        check_output("t4_overrun", overrun, 1);
        check_output("t4_rx_dout", rx_dout, 8'h34);
        read_rx();
        check_output("t4_rx_valid_clr", rx_valid, 0);
        check_output("t4_overrun_clr", overrun, 0);

        $display("[TB] abort after 5 bits, then full frame 81");
        spi_frame(1, 8'hE7, 8'h00, 5, 1'b0, 8'h00);
        @(negedge clk);
        ss_n = 1'b1;
        settle();
        check_output("t5_no_rx_valid", rx_valid, 0);
        spi_frame(1, 8'h81, 8'h00, 0, 1'b0, 8'h00);
        settle();
        check_output("t5_rx_dout", rx_dout, 8'h81);
        check_output("t5_rx_valid", rx_valid, 1);
        read_rx();

        $display("[TB] reset after 3 bits, then frame with tx 5A");
        spi_frame(1, 8'hF0, 8'h00, 3, 1'b0, 8'h00);
        do_reset();
        check_output("t6_rx_dout_rst", rx_dout, 8'h00);
        check_output("t6_rx_valid_rst", rx_valid, 0);
        check_output("t6_tx_ready_rst", tx_ready, 1);
        check_output("t6_busy_rst", busy, 0);
        write_tx(8'h5A);
        spi_frame(1, 8'hC3, 8'h00, 0, 1'b0, 8'h00);
        settle();
        check_output("t6_master_rx", recv[0], 8'h5A);
        check_output("t6_rx_dout", rx_dout, 8'hC3);

        settled = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
